icache_fetch_responder: RTL and testbench
=========================================

Name: icache_fetch_responder

Overview:
- Instruction-side responder for the fetch stage. Accepts the fetch address each cycle and returns the 32-bit instruction word in the same cycle on a hit.
- On a miss it asserts stall, fills the whole line from the main-memory port with a request/ack plus beat-stream handshake, then resumes.
- Direct-mapped, read-only, with hit/miss performance counters. Sits between the fetch stage and the memory arbiter.

Parameters:
- LINE_WORDS, 4, 32-bit words per line (power of 2, ≥2)
- NUM_LINES, 64, number of lines (power of 2)
- Derived, LINE_WORDS=4 / NUM_LINES=64: offset = addr[3:2], index = addr[9:4], tag = addr[31:10]; addr[1:0] ignored.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous, active-high reset
- Instr_address_2IM  in  32  fetch address from fetch stage
- Instr1_fIM  out  32  instruction word for the fetch address
- stall  out  1  high while requested word is unavailable; fetch stage must hold the address
- mem_req  out  1  line-fill request
- mem_addr  out  32  line-aligned fill address (offset and addr[1:0] bits = 0)
- mem_ack  in  1  memory accepted request
- mem_rvalid  in  1  one fill beat valid this cycle
- mem_rdata  in  32  fill beat data
- hit_count  out  32  fetch hits counted
- miss_count  out  32  misses counted

Behaviour:
- Reset (RESET=1 at posedge):
  - All valid bits cleared; FSM -> IDLE; beat counter = 0.
  - mem_req = 0, mem_addr = 0, hit_count = 0, miss_count = 0.
  - Tag/data arrays need no reset.
- Lookup is combinational on Instr_address_2IM.
  - hit = valid[index] && tag match && state==IDLE.
  - Instr1_fIM = data[index][offset] on hit, else 32'h0.
  - stall = !hit. This also holds outside IDLE and during the cycle RESET is asserted.
- States:
  - IDLE
    - On hit: hit_count += 1 each cycle.
    - On miss: miss_count += 1; latch line address into mem_addr; mem_req <= 1; -> REQ.
    - Miss detection costs the current cycle, so stall is 1 immediately.
  - REQ
    - mem_req held at 1 and mem_addr held stable until a cycle with mem_ack=1.
    - That cycle: mem_req <= 0; clear valid[index]; -> FILL.
    - mem_rvalid in REQ is ignored.
  - FILL
    - Each mem_rvalid beat writes mem_rdata to data[index][beat]; beat += 1.
    - Beats arrive in order, word 0 first; no back-pressure.
    - On the last beat (beat==LINE_WORDS-1): write tag, set valid[index], beat <= 0, -> IDLE.
    - The next cycle's lookup hits. Miss-to-instruction latency = 3 + ack wait + beat cycles.
- Counters wrap modulo 2^32 with no saturation. A stalled cycle is never counted as a hit.
- Address change while stalled (e.g. redirect) is a protocol violation.
  - The fill in progress still completes for the latched line.
  - The new address is looked up once back in IDLE.
- Reset mid-REQ or mid-FILL: abort immediately; state as at reset; any further mem_rvalid ignored while in IDLE.
- mem_ack outside REQ is ignored.

Test Plan:
- Cold miss. Reset, then fetch 0xBFC00000.
  - Required: stall=1 that cycle; next cycle mem_req=1, mem_addr=0xBFC00000.
  - Ack after 2 cycles; beats 0x11,0x22,0x33,0x44 on consecutive cycles.
  - Required: cycle after last beat Instr1_fIM=0x11, stall=0; miss_count=1.
- Line hits. Fetch 0xBFC00004, 0xBFC00008, 0xBFC0000C.
  - Required: 0x22, 0x33, 0x44 with stall=0 each cycle; hit_count advances by 1 per cycle.
- Conflict eviction. Fetch 0xBFC00400 (same index 0, new tag), fill 0xA0..0xA3.
  - Required: returns 0xA0.
  - Re-fetch 0xBFC00000: must miss again (miss_count +1).
- Stalled fill. Beats with gaps (rvalid 1,0,0,1,1,0,1).
  - Required: data lands in order; stall stays 1 until the cycle after the 4th beat.
- Reset mid-fill. Assert RESET after 2 beats, then issue 2 stray rvalid beats.
  - Required: mem_req=0, counters 0.
  - Stray beats ignored; fetch 0xBFC00000 misses again.
- Counter wrap. Preload or force hit_count=0xFFFFFFFF, one hit.
  - Required: hit_count=0.

Source files
------------

// File: rtl/icache_fetch_responder.sv
// Direct-mapped, read-only instruction cache responder for the fetch stage.
// A hit returns the word in the same cycle; a miss stalls while the whole line is filled.
module icache_fetch_responder #(
  parameter int LINE_WORDS = 4,
  parameter int NUM_LINES  = 64
) (
  input  logic        CLK,
  input  logic        RESET,
  input  logic [31:0] Instr_address_2IM,
  output logic [31:0] Instr1_fIM,
  output logic        stall,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] hit_count,
  output logic [31:0] miss_count
);

  localparam int OFF_W   = $clog2(LINE_WORDS);
  localparam int IDX_W   = $clog2(NUM_LINES);
  localparam int TAG_LSB = 2 + OFF_W + IDX_W;
  localparam int TAG_W   = 32 - TAG_LSB;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] FILL = 2'd2;

  logic [1:0]           state;
  logic [NUM_LINES-1:0] valid;
  logic [TAG_W-1:0]     tag_mem  [NUM_LINES];
  logic [31:0]          data_mem [NUM_LINES*LINE_WORDS];
  logic [OFF_W-1:0]     beat;

  logic [OFF_W-1:0] req_off;
  logic [IDX_W-1:0] req_idx;
  logic [TAG_W-1:0] req_tag;
  logic [IDX_W-1:0] fill_idx;
  logic [TAG_W-1:0] fill_tag;
  logic [31:0]      line_addr;
  logic             hit;
  logic             last_beat;
  logic             unused_bits;

  assign req_off   = Instr_address_2IM[2 +: OFF_W];
  assign req_idx   = Instr_address_2IM[2+OFF_W +: IDX_W];
  assign req_tag   = Instr_address_2IM[31:TAG_LSB];
  assign line_addr = {Instr_address_2IM[31:2+OFF_W], {(2+OFF_W){1'b0}}};

  // The fill target is taken from the latched request so a redirect mid-fill cannot corrupt it.
  assign fill_idx  = mem_addr[2+OFF_W +: IDX_W];
  assign fill_tag  = mem_addr[31:TAG_LSB];
  assign last_beat = (beat == OFF_W'(LINE_WORDS-1));

  assign unused_bits = ^{Instr_address_2IM[1:0], mem_addr[1+OFF_W:0]};

  assign hit        = (state == IDLE) && valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign Instr1_fIM = hit ? data_mem[{req_idx, req_off}] : 32'h0;
  assign stall      = !hit;

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state      <= IDLE;
      valid      <= '0;
      beat       <= '0;
      mem_req    <= 1'b0;
      mem_addr   <= 32'h0;
      hit_count  <= 32'h0;
      miss_count <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (hit) begin
            hit_count <= hit_count + 32'd1;
          end else begin
            miss_count <= miss_count + 32'd1;
            mem_addr   <= line_addr;
            mem_req    <= 1'b1;
            state      <= REQ;
          end
        end
        REQ: begin
          if (mem_ack) begin
            mem_req         <= 1'b0;
            valid[fill_idx] <= 1'b0;
            state           <= FILL;
          end
        end
        FILL: begin
          if (mem_rvalid) begin
            beat <= beat + 1'b1;
            if (last_beat) begin
              valid[fill_idx] <= 1'b1;
              beat            <= '0;
              state           <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Storage arrays carry no reset; the valid bits alone decide what is usable.
  always_ff @(posedge CLK) begin
    if (!RESET && state == FILL && mem_rvalid) begin
      data_mem[{fill_idx, beat}] <= mem_rdata;
      if (last_beat) begin
        tag_mem[fill_idx] <= fill_tag;
      end
    end
  end

endmodule

// File: tb/tb_icache_fetch_responder.sv
// Bench for icache_fetch_responder: directed scenarios followed by random fetches
// checked against a residency map and a synthetic main-memory function.
module tb_icache_fetch_responder;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [31:0] Instr_address_2IM;
  logic [31:0] Instr1_fIM;
  logic        stall;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] hit_count;
  logic [31:0] miss_count;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] resident [int];
  logic [21:0] tag_pool [3] = '{22'h000000, 22'h000001, 22'h2FF000};
  logic [5:0]  idx_pool [4] = '{6'd0, 6'd1, 6'd2, 6'd63};

  icache_fetch_responder dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .Instr_address_2IM(Instr_address_2IM),
    .Instr1_fIM       (Instr1_fIM),
    .stall            (stall),
    .mem_req          (mem_req),
    .mem_addr         (mem_addr),
    .mem_ack          (mem_ack),
    .mem_rvalid       (mem_rvalid),
    .mem_rdata        (mem_rdata),
    .hit_count        (hit_count),
    .miss_count       (miss_count)
  );

  always #5 CLK = ~CLK;

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic apply_stimulus(input logic [31:0] addr);
    Instr_address_2IM = addr;
    #1;
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h0BADF00D;
  endfunction

  // Plays the memory side of one line fill; entered just after the miss edge.
  task automatic serve_fill(input string name, input logic [31:0] line, input int ack_delay,
                            input logic [15:0] gaps, input logic [127:0] words);
    int guard = 0;
    while (mem_req !== 1'b1 && guard < 8) begin
      tick();
      guard++;
    end
    check_output({name, " mem_req"}, {31'b0, mem_req}, 32'd1);
    check_output({name, " mem_addr"}, mem_addr, line);
    repeat (ack_delay) begin
      tick();
      check_output({name, " req held"}, {31'b0, mem_req}, 32'd1);
    end
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    check_output({name, " req drop"}, {31'b0, mem_req}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      repeat (int'(gaps[4*i +: 4])) begin
        check_output({name, " stall gap"}, {31'b0, stall}, 32'd1);
        tick();
      end
      mem_rvalid = 1'b1;
      mem_rdata  = words[32*i +: 32];
      check_output({name, " stall beat"}, {31'b0, stall}, 32'd1);
      tick();
      mem_rvalid = 1'b0;
    end
  endtask

  initial begin
    logic [31:0]  addr;
    logic [31:0]  line;
    int           idx;
    int           exp_hit;
    int           exp_miss;
    logic [15:0]  gaps;
    logic [127:0] words;

    RESET = 1'b1;
    Instr_address_2IM = 32'h0;
    mem_ack = 1'b0;
    mem_rvalid = 1'b0;
    mem_rdata = 32'h0;
    tick();
    tick();
    RESET = 1'b0;
    check_output("reset mem_req", {31'b0, mem_req}, 32'd0);
    check_output("reset mem_addr", mem_addr, 32'h0);
    check_output("reset hit_count", hit_count, 32'd0);
    check_output("reset miss_count", miss_count, 32'd0);

    $display("[TB] cold miss");
    apply_stimulus(32'hBFC00000);
    check_output("cold stall", {31'b0, stall}, 32'd1);
    check_output("cold instr", Instr1_fIM, 32'h0);
    tick();
    check_output("cold miss_count", miss_count, 32'd1);
    serve_fill("cold", 32'hBFC00000, 2, 16'h0000, {32'h44, 32'h33, 32'h22, 32'h11});
    check_output("cold instr after fill", Instr1_fIM, 32'h11);
    check_output("cold stall after fill", {31'b0, stall}, 32'd0);
    check_output("cold miss_count after fill", miss_count, 32'd1);
    tick();
    check_output("cold hit_count", hit_count, 32'd1);

    $display("[TB] line hits");
    for (int k = 1; k < 4; k++) begin
      apply_stimulus(32'hBFC00000 + 32'(4*k));
      check_output("line hit instr", Instr1_fIM, 32'h11 * 32'(k+1));
      check_output("line hit stall", {31'b0, stall}, 32'd0);
      tick();
      check_output("line hit count", hit_count, 32'(k+1));
    end

    $display("[TB] conflict eviction");
    apply_stimulus(32'hBFC00400);
    check_output("evict stall", {31'b0, stall}, 32'd1);
    tick();
    check_output("evict miss_count", miss_count, 32'd2);
    serve_fill("evict", 32'hBFC00400, 0, 16'h0000, {32'hA3, 32'hA2, 32'hA1, 32'hA0});
    check_output("evict instr", Instr1_fIM, 32'hA0);
    check_output("evict stall after fill", {31'b0, stall}, 32'd0);
    apply_stimulus(32'hBFC00000);
    check_output("refetch stall", {31'b0, stall}, 32'd1);
    tick();
    check_output("refetch miss_count", miss_count, 32'd3);

    $display("[TB] gapped fill");
    serve_fill("gapfill", 32'hBFC00000, 1, 16'h1020, {32'h44, 32'h33, 32'h22, 32'h11});
    check_output("gapfill instr0", Instr1_fIM, 32'h11);
    check_output("gapfill stall", {31'b0, stall}, 32'd0);
    apply_stimulus(32'hBFC0000C);
    check_output("gapfill instr3", Instr1_fIM, 32'h44);
    tick();
    check_output("gapfill hit_count", hit_count, 32'd5);

    $display("[TB] reset mid-fill");
    apply_stimulus(32'h00001230);
    tick();
    check_output("midfill miss_count", miss_count, 32'd4);
    mem_ack = 1'b1;
    tick();
    mem_ack = 1'b0;
    mem_rvalid = 1'b1;
    mem_rdata = 32'h55;
    tick();
    mem_rdata = 32'h66;
    tick();
    mem_rvalid = 1'b0;
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    apply_stimulus(32'hBFC00000);
    check_output("midfill mem_req", {31'b0, mem_req}, 32'd0);
    check_output("midfill mem_addr", mem_addr, 32'h0);
    check_output("midfill hit_count", hit_count, 32'd0);
    check_output("midfill miss_count", miss_count, 32'd0);
    check_output("midfill stall", {31'b0, stall}, 32'd1);
    mem_rvalid = 1'b1;
    mem_rdata = 32'hDEADBEEF;
    tick();
    check_output("stray miss_count", miss_count, 32'd1);
    tick();
    mem_rvalid = 1'b0;
    serve_fill("postreset", 32'hBFC00000, 0, 16'h0000, {32'h44, 32'h33, 32'h22, 32'h11});
    check_output("postreset instr0", Instr1_fIM, 32'h11);
    apply_stimulus(32'hBFC0000C);
    check_output("postreset instr3", Instr1_fIM, 32'h44);
    tick();
    check_output("postreset hit_count", hit_count, 32'd1);

    $display("[TB] counter wrap");
    force dut.hit_count = 32'hFFFFFFFF;
    #1;
    release dut.hit_count;
    tick();
    check_output("wrap hit_count", hit_count, 32'h0);

    $display("[TB] random fetches");
    RESET = 1'b1;
    tick();
    RESET = 1'b0;
    resident.delete();
    exp_hit = 0;
    exp_miss = 0;
    repeat (80) begin
      addr = {tag_pool[$urandom_range(0, 2)], idx_pool[$urandom_range(0, 3)], 4'($urandom_range(0, 15))};
      apply_stimulus(addr);
      line = addr & ~32'hF;
      idx  = int'(addr[9:4]);
      if (resident.exists(idx) && resident[idx] == line) begin
        check_output("rand hit stall", {31'b0, stall}, 32'd0);
        check_output("rand hit instr", Instr1_fIM, mem_word(addr & ~32'h3));
        tick();
        exp_hit++;
        check_output("rand hit_count", hit_count, 32'(exp_hit));
      end else begin
        check_output("rand miss stall", {31'b0, stall}, 32'd1);
        check_output("rand miss instr", Instr1_fIM, 32'h0);
        tick();
        exp_miss++;
        check_output("rand miss_count", miss_count, 32'(exp_miss));
        for (int i = 0; i < 4; i++) begin
          gaps[4*i +: 4]   = 4'($urandom_range(0, 2));
          words[32*i +: 32] = mem_word(line + 32'(4*i));
        end
        serve_fill("rand", line, int'($urandom_range(0, 3)), gaps, words);
        resident[idx] = line;
        check_output("rand fill instr", Instr1_fIM, mem_word(addr & ~32'h3));
        check_output("rand fill stall", {31'b0, stall}, 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
